// File: rtl/lane_combiner_if.sv
// -----------------------------------------------------------------------------
// lane_combiner_if
// Bundles the lane-side inputs, the output handshake and the status flags of
// lane_combiner.
//   master : drives lane_data/lane_valid/flush/out_ready, observes the rest
//   slave  : the combiner itself
// Signals:
//   lane_data     NUM_LANES*LANE_WIDTH  lane i at [i*LANE_WIDTH +: LANE_WIDTH]
//   lane_valid    NUM_LANES             per-lane push strobe
//   flush         1                     synchronous clear
//   out_data      NUM_LANES*LANE_WIDTH  combined word, lane 0 in LSBs
//   out_valid     1                     out_data holds a word
//   out_ready     1                     consumer accept
//   lane_overflow NUM_LANES             sticky per-lane drop flag
//   skew_err      1                     one-cycle skew timeout pulse
//   word_count    16                    accepted-word counter
// -----------------------------------------------------------------------------
interface lane_combiner_if #(
    parameter int NUM_LANES  = 4,
    parameter int LANE_WIDTH = 8
);
    logic [NUM_LANES*LANE_WIDTH-1:0] lane_data;
    logic [NUM_LANES-1:0]            lane_valid;
    logic                            flush;
    logic [NUM_LANES*LANE_WIDTH-1:0] out_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_LANES-1:0]            lane_overflow;
    logic                            skew_err;
    logic [15:0]                     word_count;

    modport master (
        output lane_data, lane_valid, flush, out_ready,
        input  out_data, out_valid, lane_overflow, skew_err, word_count
    );

    modport slave (
        input  lane_data, lane_valid, flush, out_ready,
        output out_data, out_valid, lane_overflow, skew_err, word_count
    );
endinterface

// File: rtl/lane_combiner.sv
// -----------------------------------------------------------------------------
// lane_combiner
// Buffers NUM_LANES skewed lanes in per-lane deskew FIFOs and emits one
// registered combined word over valid/ready whenever every lane holds data.
// Flags sticky per-lane overflow and times out lanes that stay partially
// filled for SKEW_LIMIT cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    lane_combiner_if.slave (lanes in, combined word out, status)
// Optional feature: define LANE_COMBINER_STATS_EN to count accepted words on
// bus.word_count; otherwise word_count is tied to zero.
// Contains lane_fifo (per-lane FIFO) used as an array of instances.
// -----------------------------------------------------------------------------

// Per-lane FIFO. Pointers carry one extra wrap bit; full when the wrap bits
// differ and the index bits match.
module lane_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,  // clears pointers and overflow flag
    input  logic         drop_i,   // clears pointers only (skew timeout)
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         ovf_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic         ovf_q, ovf_d;
    logic         full, wr_en;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign wr_en   = push_i && (!full || pop_i) && !flush_i && !drop_i;
    assign dout_o  = mem_q[rptr_q[AW-1:0]];
    assign ovf_o   = ovf_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            ovf_d  = 1'b0;
        end else if (drop_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_en)            wptr_d = wptr_q + 1'b1;
            if (pop_i)            rptr_d = rptr_q + 1'b1;
            if (push_i && !wr_en) ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= din_i;
    end
endmodule

module lane_combiner #(
    parameter int NUM_LANES  = 4,
    parameter int LANE_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SKEW_LIMIT = 16
) (
    input logic           clk,
    input logic           rst_n,
    lane_combiner_if.slave bus
);
    localparam int DW = NUM_LANES * LANE_WIDTH;
    localparam int CW = $clog2(SKEW_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_PARTIAL, S_FULL} skew_state_t;

    typedef struct packed {
        logic          vld;
        logic [DW-1:0] data;
    } out_stage_t;

    logic [NUM_LANES-1:0][LANE_WIDTH-1:0] lane_in, head;
    logic [NUM_LANES-1:0]                 empty, ovf, push;
    logic                                 all_ne, any_ne, pop, timeout;
    skew_state_t                          state_q, state_d;
    logic [CW-1:0]                        cnt_q, cnt_d;
    out_stage_t                           out_q, out_d;
    logic                                 skew_err_q;

    assign lane_in = bus.lane_data;
    assign all_ne  = &(~empty);
    assign any_ne  = |(~empty);
    assign pop     = all_ne && (!out_q.vld || bus.out_ready) && !bus.flush;
    assign push    = bus.lane_valid & {NUM_LANES{!bus.flush && !timeout}};

    lane_fifo #(.W(LANE_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo [NUM_LANES-1:0] (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (bus.flush),
        .drop_i  (timeout),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (lane_in),
        .dout_o  (head),
        .empty_o (empty),
        .ovf_o   (ovf)
    );

    // Skew monitor: cnt_q counts cycles already spent in PARTIAL, so the
    // timeout fires during the SKEW_LIMIT-th partial cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timeout = 1'b0;
        if (bus.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (all_ne)      state_d = S_FULL;
                    else if (any_ne) state_d = S_PARTIAL;
                end
                S_PARTIAL: begin
                    if (all_ne) begin
                        state_d = S_FULL;
                        cnt_d   = '0;
                    end else if (!any_ne) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(SKEW_LIMIT - 1)) begin
                        timeout = 1'b1;
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_FULL: begin
                    cnt_d = '0;
                    if (!any_ne)      state_d = S_IDLE;
                    else if (!all_ne) state_d = S_PARTIAL;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        out_d = out_q;
        if (bus.flush) begin
            out_d = '0;
        end else if (pop) begin
            out_d.vld  = 1'b1;
            out_d.data = head;
        end else if (out_q.vld && bus.out_ready) begin
            out_d.vld = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            out_q      <= '0;
            skew_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            skew_err_q <= timeout;
        end
    end

    assign bus.out_data      = out_q.data;
    assign bus.out_valid     = out_q.vld;
    assign bus.lane_overflow = ovf;
    assign bus.skew_err      = skew_err_q;

`ifdef LANE_COMBINER_STATS_EN
    logic [15:0] wc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       wc_q <= '0;
        else if (out_q.vld && bus.out_ready && !bus.flush) wc_q <= wc_q + 16'd1;
    end

    assign bus.word_count = wc_q;
`else
    assign bus.word_count = '0;
`endif
endmodule

// File: tb/tb_lane_combiner.sv
// -----------------------------------------------------------------------------
// tb_lane_combiner
// Bench for lane_combiner: a 4x8 main instance checked through a scoreboard
// of expected words, plus 3x16 / 1x8 instances with depth-2 FIFOs.
// -----------------------------------------------------------------------------
module tb_lane_combiner;
    logic clk, rst_n;
    int   checks = 0;
    int   errors = 0;
    int   skew_pulses = 0;
    int   hs_count = 0;
    logic stall_seen = 1'b0;
    logic [31:0] held;
    logic [31:0] exp_q [$];

    lane_combiner_if #(.NUM_LANES(4), .LANE_WIDTH(8)) bus ();
    lane_combiner #(.NUM_LANES(4), .LANE_WIDTH(8), .FIFO_DEPTH(4), .SKEW_LIMIT(16))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    lane_combiner_if #(.NUM_LANES(3), .LANE_WIDTH(16)) bus3 ();
    lane_combiner #(.NUM_LANES(3), .LANE_WIDTH(16), .FIFO_DEPTH(2), .SKEW_LIMIT(16))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    lane_combiner_if #(.NUM_LANES(1), .LANE_WIDTH(8)) bus1 ();
    lane_combiner #(.NUM_LANES(1), .LANE_WIDTH(8), .FIFO_DEPTH(2), .SKEW_LIMIT(16))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard / hold monitor for the main instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_seen = 1'b0;
            hs_count   = 0;
        end else begin
            if (bus.skew_err) skew_pulses++;
            if (stall_seen) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_data", 64'(bus.out_data), 64'(held));
            end
            if (bus.out_valid && bus.out_ready && !bus.flush) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
                end else begin
                    check("word", 64'(bus.out_data), 64'(exp_q.pop_front()));
                end
            end
            stall_seen = bus.out_valid && !bus.out_ready && !bus.flush;
            held       = bus.out_data;
        end
    end

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [47:0] w3(input int i);
        logic [15:0] x;
        x = 16'(i);
        return {16'hC000 | x, 16'hB000 | x, 16'hA000 | x};
    endfunction

    task automatic check_wc(input string name);
`ifdef LANE_COMBINER_STATS_EN
        check(name, 64'(bus.word_count), 64'(hs_count));
`else
        check(name, 64'(bus.word_count), 64'd0);
`endif
    endtask

    initial begin
        vec_t vecs [4];
        int   k;
        int   base;

        vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
        vecs[1] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'hDDCCBBAA};
        vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 32'hFF00FF00};
        vecs[3] = '{8'h01, 8'h02, 8'h04, 8'h80, 32'h80040201};

        rst_n = 1'b0;
        bus.lane_data = '0;  bus.lane_valid = '0;  bus.flush = 1'b0;  bus.out_ready = 1'b1;
        bus3.lane_data = '0; bus3.lane_valid = '0; bus3.flush = 1'b0; bus3.out_ready = 1'b1;
        bus1.lane_data = '0; bus1.lane_valid = '0; bus1.flush = 1'b0; bus1.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_overflow", 64'(bus.lane_overflow), 64'd0);
        check("rst_skew_err", 64'(bus.skew_err), 64'd0);
        check("rst_word_count", 64'(bus.word_count), 64'd0);
        rst_n = 1'b1;
        step();

        // Aligned lanes, one word at a time, with latency check.
        for (int i = 0; i < 4; i++) begin
            bus.lane_data  = {vecs[i].b3, vecs[i].b2, vecs[i].b1, vecs[i].b0};
            bus.lane_valid = 4'hF;
            exp_q.push_back(vecs[i].exp);
            step();
            bus.lane_valid = 4'h0;
            @(negedge clk);
            check("latency_t1", 64'(bus.out_valid), 64'd0);
            @(negedge clk);
            check("latency_t2", 64'(bus.out_valid), 64'd1);
            step();
            step();
        end
        check_wc("wc_aligned");

        // Back-to-back throughput.
        for (int i = 0; i < 4; i++) begin
            bus.lane_data  = {vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3};
            bus.lane_valid = 4'hF;
            exp_q.push_back({vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3});
            step();
        end
        bus.lane_valid = 4'h0;
        repeat (4) step();
        check("throughput_drained", 64'(exp_q.size()), 64'd0);

        // Skewed arrival: lane 2 three cycles late.
        base = skew_pulses;
        bus.lane_data  = 32'h8D7C6B5A;
        bus.lane_valid = 4'b1011;
        step();
        bus.lane_valid = 4'h0;
        repeat (2) step();
        check("skew_no_early_word", 64'(bus.out_valid), 64'd0);
        bus.lane_valid = 4'b0100;
        exp_q.push_back(32'h8D7C6B5A);
        step();
        bus.lane_valid = 4'h0;
        repeat (4) step();
        check("skew_word_drained", 64'(exp_q.size()), 64'd0);
        check("skew_no_err", 64'(skew_pulses - base), 64'd0);

        // Backpressure: 6 pushes while stalled, the 6th is dropped.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.lane_data  = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            bus.lane_valid = 4'hF;
            if (i < 5) exp_q.push_back({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
            step();
        end
        bus.lane_valid = 4'h0;
        check("bp_overflow", 64'(bus.lane_overflow), 64'hF);
        bus.out_ready = 1'b1;
        repeat (8) step();
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_overflow_sticky", 64'(bus.lane_overflow), 64'hF);
        check_wc("wc_bp");

        // Flush with a word in the register and one in the FIFOs.
        bus.out_ready  = 1'b0;
        bus.lane_valid = 4'hF;
        bus.lane_data  = 32'hA1A2A3A4;
        step();
        bus.lane_data  = 32'hB1B2B3B4;
        step();
        bus.lane_valid = 4'h0;
        repeat (2) step();
        check("pre_flush_valid", 64'(bus.out_valid), 64'd1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_overflow", 64'(bus.lane_overflow), 64'd0);
        step();
        bus.out_ready  = 1'b1;
        bus.lane_data  = 32'hC1C2C3C4;
        bus.lane_valid = 4'hF;
        exp_q.push_back(32'hC1C2C3C4);
        step();
        bus.lane_valid = 4'h0;
        repeat (4) step();
        check("post_flush_drained", 64'(exp_q.size()), 64'd0);
        check_wc("wc_flush");

        // Skew timeout: only lane 0 pushes.
        base = skew_pulses;
        bus.lane_data  = 32'h000000E7;
        bus.lane_valid = 4'b0001;
        step();
        bus.lane_valid = 4'h0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.skew_err) break;
        end
        check("skew_timeout_cycle", 64'(k), 64'd18);
        @(negedge clk);
        check("skew_pulse_width", 64'(bus.skew_err), 64'd0);
        step();
        check("skew_pulse_count", 64'(skew_pulses - base), 64'd1);
        check("skew_no_word", 64'(bus.out_valid), 64'd0);
        bus.lane_data  = 32'h0F0E0D0C;
        bus.lane_valid = 4'hF;
        exp_q.push_back(32'h0F0E0D0C);
        step();
        bus.lane_valid = 4'h0;
        repeat (4) step();
        check("skew_fifo0_clean", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 5; i++) begin
            bus.lane_data  = 32'h50607080 + 32'(i);
            bus.lane_valid = 4'hF;
            exp_q.push_back(32'h50607080 + 32'(i));
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus.out_valid), 64'd0);
        check("arst_data", 64'(bus.out_data), 64'd0);
        check("arst_overflow", 64'(bus.lane_overflow), 64'd0);
        check("arst_word_count", 64'(bus.word_count), 64'd0);
        exp_q.delete();
        bus.lane_valid = 4'h0;
        step();
        rst_n = 1'b1;
        step();
        bus.lane_data  = 32'h12345678;
        bus.lane_valid = 4'hF;
        exp_q.push_back(32'h12345678);
        step();
        bus.lane_valid = 4'h0;
        repeat (4) step();
        check("post_arst_drained", 64'(exp_q.size()), 64'd0);
        check_wc("wc_post_arst");

        // 3 lanes x 16 bits, depth 2: fill, overflow, drain, wrap.
        bus3.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus3.lane_data  = w3(i);
            bus3.lane_valid = 3'b111;
            step();
        end
        bus3.lane_valid = 3'b000;
        check("p3_overflow", 64'(bus3.lane_overflow), 64'h7);
        check("p3_held", 64'(bus3.out_data), 64'(w3(0)));
        bus3.out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("p3_drain_valid", 64'(bus3.out_valid), 64'd1);
            check("p3_drain_data", 64'(bus3.out_data), 64'(w3(j)));
        end
        @(negedge clk);
        check("p3_empty", 64'(bus3.out_valid), 64'd0);
        step();
        bus3.lane_valid = 3'b111;
        bus3.lane_data  = w3(4);
        step();
        bus3.lane_data  = w3(5);
        step();
        bus3.lane_valid = 3'b000;
        @(negedge clk);
        check("p3_wrap_a", 64'(bus3.out_data), 64'(w3(4)));
        @(negedge clk);
        check("p3_wrap_b", 64'(bus3.out_data), 64'(w3(5)));
        check("p3_wrap_valid", 64'(bus3.out_valid), 64'd1);

        // Single lane: streaming, then depth-2 overflow.
        bus1.lane_valid = 1'b1;
        bus1.lane_data  = 8'h5A;
        step();
        bus1.lane_data  = 8'hA5;
        step();
        bus1.lane_valid = 1'b0;
        @(negedge clk);
        check("p1_a", 64'(bus1.out_data), 64'h5A);
        @(negedge clk);
        check("p1_b", 64'(bus1.out_data), 64'hA5);
        step();
        bus1.out_ready  = 1'b0;
        bus1.lane_valid = 1'b1;
        repeat (4) step();
        bus1.lane_valid = 1'b0;
        check("p1_overflow", 64'(bus1.lane_overflow), 64'd1);
        check("p1_no_skew", 64'(bus1.skew_err), 64'd0);

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
